// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues same-cycle instruction memory reads,
// and buffers {pc, instr} in a small in-order queue toward decode. Optional macro: IFETCH_PERF_CNT_EN.
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fetch_en_i,
   output logic [31:0] imem_addr_o,
   output logic        imem_ren_o,
   input  logic [31:0] imem_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_instr_o,
`ifdef IFETCH_PERF_CNT_EN
   output logic [31:0] perf_fetched_o,
   output logic [31:0] perf_stall_o,
`endif
   output logic [31:0] id_pc_o
);

   localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW = $clog2(QDEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

   typedef enum logic {BOOT, RUN} state_t;

   state_t          state_reg;
   logic [31:0]     pc_reg;
   logic [PW-1:0]   wr_ptr_reg;
   logic [PW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [31:0]     q_pc_reg    [QDEPTH];
   logic [31:0]     q_instr_reg [QDEPTH];

   logic head_valid;
   logic pop;
   logic can_push;
   logic push;

   // Outputs are forced to their reset values while reset is held, so they are
   // defined even before the first reset edge has been seen.
   always_comb begin
      head_valid = rst_ni && (count_reg != '0);
      pop        = head_valid && id_ready_i;
      can_push   = (count_reg < DEPTH_C) || pop;
      push       = rst_ni && (state_reg == RUN) && fetch_en_i && can_push && !redirect_i;
   end

   assign imem_addr_o = rst_ni ? pc_reg : RESET_PC;
   assign imem_ren_o  = push;
   assign id_valid_o  = head_valid;
   assign id_instr_o  = head_valid ? q_instr_reg[rd_ptr_reg] : 32'h0;
   assign id_pc_o     = head_valid ? q_pc_reg[rd_ptr_reg]    : 32'h0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg  <= BOOT;
         pc_reg     <= RESET_PC;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (redirect_i) begin
         // Flush wins over any same-cycle pop; push is already blocked by redirect.
         state_reg  <= RUN;
         pc_reg     <= {redirect_pc_i[31:2], 2'b00};
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (state_reg == BOOT && fetch_en_i) begin
            state_reg <= RUN;
         end
         if (push) begin
            pc_reg     <= pc_reg + 32'd4;
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   // Queue storage needs no reset: entries are only visible below count_reg.
   generate
      for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_entry
         always_ff @(posedge clk_i) begin
            if (push && (wr_ptr_reg == PW'(gi))) begin
               q_pc_reg[gi]    <= pc_reg;
               q_instr_reg[gi] <= imem_data_i;
            end
         end
      end
   endgenerate

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_reg;
   logic [31:0] perf_stall_reg;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_fetched_reg <= 32'h0;
         perf_stall_reg   <= 32'h0;
      end else begin
         if (push) begin
            perf_fetched_reg <= perf_fetched_reg + 32'd1;
         end
         if ((state_reg == RUN) && fetch_en_i && !redirect_i && !can_push) begin
            perf_stall_reg <= perf_stall_reg + 32'd1;
         end
      end
   end

   assign perf_fetched_o = perf_fetched_reg;
   assign perf_stall_o   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed table-driven bench for instr_fetch_stage, with a second instance at a
// wrapping RESET_PC sharing the same control stimulus.
module tb_instr_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_ready = 1'b1;

   logic [31:0] imem_addr, imem_data, id_instr, id_pc;
   logic        imem_ren, id_valid;
   logic [31:0] imem_addr2, imem_data2, id_instr2, id_pc2;
   logic        imem_ren2, id_valid2;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   // Memory model: word k holds 0x11*(k+1).
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a >> 2) * 32'h11 + 32'h11;
   endfunction

   always_comb imem_data  = mem_word(imem_addr);
   always_comb imem_data2 = mem_word(imem_addr2);

   instr_fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en),
      .imem_addr_o(imem_addr), .imem_ren_o(imem_ren), .imem_data_i(imem_data),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .id_valid_o(id_valid), .id_ready_i(id_ready), .id_instr_o(id_instr),
`ifdef IFETCH_PERF_CNT_EN
      .perf_fetched_o(perf_fetched), .perf_stall_o(perf_stall),
`endif
      .id_pc_o(id_pc)
   );

   instr_fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en),
      .imem_addr_o(imem_addr2), .imem_ren_o(imem_ren2), .imem_data_i(imem_data2),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc),
      .id_valid_o(id_valid2), .id_ready_i(id_ready), .id_instr_o(id_instr2),
`ifdef IFETCH_PERF_CNT_EN
      .perf_fetched_o(perf_fetched2), .perf_stall_o(perf_stall2),
`endif
      .id_pc_o(id_pc2)
   );

   typedef struct {
      logic        rst_n, fe, rdy, redir;
      logic [31:0] rpc;
      logic        ren;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc, instr, addr2, pc2;
   } vec_t;

   vec_t tbl [17];

   function automatic vec_t mk(input logic r, input logic f, input logic y, input logic d,
                               input logic [31:0] rp, input logic en, input logic [31:0] ad,
                               input logic v, input logic [31:0] p, input logic [31:0] ins,
                               input logic [31:0] ad2, input logic [31:0] p2);
      vec_t t;
      t.rst_n = r; t.fe = f; t.rdy = y; t.redir = d; t.rpc = rp;
      t.ren = en; t.addr = ad; t.valid = v; t.pc = p; t.instr = ins;
      t.addr2 = ad2; t.pc2 = p2;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input logic r, input logic f, input logic y, input logic d,
                        input logic [31:0] rp);
      @(negedge clk);
      rst_n = r; fetch_en = f; id_ready = y; redirect = d; redirect_pc = rp;
      #1;
   endtask

   task automatic chk_main(input string tag, input logic en, input logic [31:0] ad,
                           input logic v, input logic [31:0] p, input logic [31:0] ins);
      chk({tag, ".ren"}, 32'(imem_ren), 32'(en));
      chk({tag, ".addr"}, imem_addr, ad);
      chk({tag, ".valid"}, 32'(id_valid), 32'(v));
      chk({tag, ".pc"}, id_pc, p);
      chk({tag, ".instr"}, id_instr, ins);
      $display("%s ren=%0b addr=%h valid=%0b pc=%h instr=%h", tag, imem_ren, imem_addr,
               id_valid, id_pc, id_instr);
   endtask

   initial begin
      //             rst fe rdy rd rpc            ren addr          v  pc            instr         addr2         pc2
      tbl[0]  = mk(0, 1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   32'hFFFF_FFF8, 32'h0);
      tbl[1]  = mk(0, 1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   32'hFFFF_FFF8, 32'h0);
      tbl[2]  = mk(1, 1, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   32'hFFFF_FFF8, 32'h0);
      tbl[3]  = mk(1, 1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0,   32'hFFFF_FFF8, 32'h0);
      tbl[4]  = mk(1, 1, 1, 0, 32'h0,   1, 32'h4,   1, 32'h0,   32'h11,  32'hFFFF_FFFC, 32'hFFFF_FFF8);
      tbl[5]  = mk(1, 1, 1, 0, 32'h0,   1, 32'h8,   1, 32'h4,   32'h22,  32'h0000_0000, 32'hFFFF_FFFC);
      tbl[6]  = mk(1, 1, 1, 0, 32'h0,   1, 32'hC,   1, 32'h8,   32'h33,  32'h0000_0004, 32'h0000_0000);
      tbl[7]  = mk(1, 1, 0, 0, 32'h0,   1, 32'h10,  1, 32'hC,   32'h44,  32'h8,         32'h4);
      tbl[8]  = mk(1, 1, 0, 0, 32'h0,   0, 32'h14,  1, 32'hC,   32'h44,  32'hC,         32'h4);
      tbl[9]  = mk(1, 1, 0, 0, 32'h0,   0, 32'h14,  1, 32'hC,   32'h44,  32'hC,         32'h4);
      tbl[10] = mk(1, 1, 1, 0, 32'h0,   1, 32'h14,  1, 32'hC,   32'h44,  32'hC,         32'h4);
      tbl[11] = mk(1, 1, 1, 1, 32'h103, 0, 32'h18,  1, 32'h10,  32'h55,  32'h10,        32'h8);
      tbl[12] = mk(1, 1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0,   32'h0,   32'h100,       32'h0);
      tbl[13] = mk(1, 0, 0, 0, 32'h0,   0, 32'h104, 1, 32'h100, 32'h451, 32'h104,       32'h100);
      tbl[14] = mk(1, 0, 1, 0, 32'h0,   0, 32'h104, 1, 32'h100, 32'h451, 32'h104,       32'h100);
      tbl[15] = mk(1, 0, 1, 0, 32'h0,   0, 32'h104, 0, 32'h0,   32'h0,   32'h104,       32'h0);
      tbl[16] = mk(0, 0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   32'hFFFF_FFF8, 32'h0);

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].rst_n, tbl[i].fe, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
         chk_main($sformatf("vec%0d", i), tbl[i].ren, tbl[i].addr, tbl[i].valid,
                  tbl[i].pc, tbl[i].instr);
         chk($sformatf("vec%0d.addr2", i), imem_addr2, tbl[i].addr2);
         chk($sformatf("vec%0d.pc2", i), id_pc2, tbl[i].pc2);
      end

      // Back-pressure from the first fetch, then drain without gaps.
      drive(1, 1, 0, 0, 32'h0);
      chk_main("bp0", 0, 32'h0, 0, 32'h0, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
      chk("perf0.fetched", perf_fetched, 32'd0);
      chk("perf0.stall", perf_stall, 32'd0);
`endif
      drive(1, 1, 0, 0, 32'h0);
      chk_main("bp1", 1, 32'h0, 0, 32'h0, 32'h0);
      drive(1, 1, 0, 0, 32'h0);
      chk_main("bp2", 1, 32'h4, 1, 32'h0, 32'h11);
      drive(1, 1, 0, 0, 32'h0);
      chk_main("bp3", 0, 32'h8, 1, 32'h0, 32'h11);
      drive(1, 1, 0, 0, 32'h0);
      chk_main("bp4", 0, 32'h8, 1, 32'h0, 32'h11);
      drive(1, 1, 1, 0, 32'h0);
      chk_main("bp5", 1, 32'h8, 1, 32'h0, 32'h11);
`ifdef IFETCH_PERF_CNT_EN
      chk("perf5.fetched", perf_fetched, 32'd2);
      chk("perf5.stall", perf_stall, 32'd2);
`endif
      drive(1, 1, 1, 0, 32'h0);
      chk_main("bp6", 1, 32'hC, 1, 32'h4, 32'h22);
`ifdef IFETCH_PERF_CNT_EN
      chk("perf6.fetched", perf_fetched, 32'd3);
      chk("perf6.stall", perf_stall, 32'd2);
`endif

      // Fill the queue, then redirect while full with pop and push both possible.
      drive(1, 1, 0, 0, 32'h0);
      chk_main("rf0", 0, 32'h10, 1, 32'h8, 32'h33);
      drive(1, 1, 1, 1, 32'h0000_0202);
      chk_main("rf1", 0, 32'h10, 1, 32'h8, 32'h33);
      drive(1, 1, 1, 0, 32'h0);
      chk_main("rf2", 1, 32'h200, 0, 32'h0, 32'h0);
      drive(1, 1, 0, 0, 32'h0);
      chk_main("rf3", 1, 32'h204, 1, 32'h200, 32'h891);
      drive(1, 1, 0, 0, 32'h0);
      chk_main("rf4", 0, 32'h208, 1, 32'h200, 32'h891);

      // Reset with two entries queued, then confirm BOOT holds off reads.
      drive(0, 1, 0, 0, 32'h0);
      chk_main("rs0", 0, 32'h0, 0, 32'h0, 32'h0);
      drive(1, 0, 1, 0, 32'h0);
      chk_main("rs1", 0, 32'h0, 0, 32'h0, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
      chk("perfrs.fetched", perf_fetched, 32'd0);
      chk("perfrs.stall", perf_stall, 32'd0);
`endif
      drive(1, 1, 1, 0, 32'h0);
      chk_main("rs2", 0, 32'h0, 0, 32'h0, 32'h0);
      drive(1, 1, 1, 0, 32'h0);
      chk_main("rs3", 1, 32'h0, 0, 32'h0, 32'h0);
      drive(1, 1, 1, 0, 32'h0);
      chk_main("rs4", 1, 32'h4, 1, 32'h0, 32'h11);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
